// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state encoding and default widths for the ring-oscillator measurement controller
package ro_meas_pkg;
  localparam int DEF_WIN_W = 16;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_SETTLE = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_MEAS = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/ro_meas_ctrl_if.sv
// ro_meas_ctrl_if: control (start/abort/window), RO macro (ro_div/ro_en) and readout (busy/done/count/ovf) signals
interface ro_meas_ctrl_if import ro_meas_pkg::*; #(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic start, abort, ro_div, ro_en, busy, done, ovf;
  logic [WIN_W-1:0] window;
  logic [CNT_W-1:0] count;
  modport master (output start, abort, window, ro_div, input ro_en, busy, done, count, ovf);
  modport slave (input start, abort, window, ro_div, output ro_en, busy, done, count, ovf);
endinterface

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: 2-FF synchronizer plus delay FF on ro_div; rise is a one-cycle pulse per rising edge (ports clk, reset, ro_div -> rise)
module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ro_div,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else sr <= {sr[1:0], ro_div};
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl: enables the RO, waits SETTLE cycles, counts ro_div rises over WINDOW cycles, reports count/ovf with a done pulse (ports clk, reset, bus)
module ro_meas_ctrl import ro_meas_pkg::*; #(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input logic clk,
  input logic reset,
  ro_meas_ctrl_if.slave bus
);
  localparam int SW = $clog2(SETTLE + 1);
  state_t state, state_nxt;
  logic rise, inc, go, ro_en_q, ovf_s, ovf_nxt, ovf_q;
  logic [SW-1:0] st_cnt;
  logic [WIN_W-1:0] win_q, win_cnt;
  logic [CNT_W-1:0] cnt, cnt_nxt, count_q;
  ro_edge_sync u_sync (.clk(clk), .reset(reset), .ro_div(bus.ro_div), .rise(rise));
  assign go = state == S_IDLE && bus.start && !bus.abort;
  assign inc = state == S_MEAS && rise;
  assign cnt_nxt = inc && !(&cnt) ? cnt + CNT_W'(1) : cnt;
  assign ovf_nxt = ovf_s | (inc & (&cnt));
  assign bus.ro_en = ro_en_q;
  assign bus.count = count_q;
  assign bus.ovf = ovf_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = !go ? S_IDLE : bus.window == '0 ? S_DONE : S_SETTLE;
      S_SETTLE: state_nxt = st_cnt == SW'(SETTLE - 1) ? S_MEAS : S_SETTLE;
      S_MEAS:   state_nxt = win_cnt == win_q - WIN_W'(1) ? S_DONE : S_MEAS;
      default:  state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
    bus.busy = state != S_IDLE;
    bus.done = state == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ro_en_q <= 1'b0;
      st_cnt <= '0;
      win_cnt <= '0;
      win_q <= '0;
      cnt <= '0;
      ovf_s <= 1'b0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ro_en_q <= state_nxt == S_SETTLE || state_nxt == S_MEAS;
      st_cnt <= state == S_SETTLE ? st_cnt + SW'(1) : '0;
      win_cnt <= state == S_MEAS ? win_cnt + WIN_W'(1) : '0;
      if (go) win_q <= bus.window;
      cnt <= go ? '0 : cnt_nxt;
      ovf_s <= go ? 1'b0 : ovf_nxt;
      if (state_nxt == S_DONE) begin
        count_q <= state == S_MEAS ? cnt_nxt : '0;
        ovf_q <= state == S_MEAS && ovf_nxt;
      end
    end
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb_ro_meas_ctrl: randomized scoreboard bench for ro_meas_ctrl
module tb_ro_meas_ctrl;
  localparam int WIN_W = 16, CNT_W = 4, SETTLE = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {int done_cyc; int en_first; int en_len; int n; int tol;} exp_t;
  logic clk = 0, reset = 0;
  int cyc = 0, per = 10, ph = 0, checks = 0, errors = 0;
  int en_len = 0, en_first = 0;
  bit prev_done = 0;
  exp_t sbq[$];
  exp_t mon_e;
  ro_meas_ctrl_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();
  ro_meas_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #3;
    bus.ro_div = ((cyc + ph) % per) < per / 2;
  end
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic check_count(input exp_t e);
    bit ok = 0;
    for (int k = e.n - e.tol; k <= e.n + e.tol; k++)
      if (k >= 0 && bus.count == CNT_W'(k > CMAX ? CMAX : k) && bus.ovf == (k > CMAX)) ok = 1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL count got %0d ovf %0d want %0d+-%0d saturating at %0d", bus.count, bus.ovf, e.n, e.tol, CMAX);
    end
  endtask
  always @(negedge clk) begin
    if (prev_done) begin
      check("done_pulse_len", bus.done, 0);
      check("idle_after_done", bus.busy, 0);
    end
    prev_done = bus.done;
    if (bus.ro_en) begin
      if (en_len == 0) en_first = cyc;
      en_len++;
      check("ro_en_implies_busy", bus.busy, 1);
    end
    if (bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("done_busy", bus.busy, 1);
        check("done_ro_en", bus.ro_en, 0);
        check("ro_en_len", en_len, mon_e.en_len);
        if (mon_e.en_len > 0) check("ro_en_first", en_first, mon_e.en_first);
        check_count(mon_e);
      end
    end
    if (!bus.busy) en_len = 0;
  end
  function automatic int edges(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if ((c + ph) % per == 0) n++;
    return n;
  endfunction
  task automatic launch(input int w, input int p, output int s);
    per = p;
    ph = $urandom_range(0, p - 1);
    s = cyc;
    bus.window = WIN_W'(w);
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
  endtask
  task automatic measure(input int w, input int p, input bit noise);
    int s, d;
    exp_t e;
    launch(w, p, s);
    d = s + 1 + (w == 0 ? 0 : SETTLE + w);
    e.done_cyc = d;
    e.en_first = s + 1;
    e.en_len = w == 0 ? 0 : SETTLE + w;
    e.n = edges(s + 1 + SETTLE, s + SETTLE + w);
    e.tol = w == 0 ? 0 : 1;
    sbq.push_back(e);
    if (noise) begin
      while (cyc < d) begin
        bus.start = 1'($urandom);
        bus.window = WIN_W'($urandom);
        @(posedge clk); #1;
      end
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
    end
    for (int i = 0; i < SETTLE + w + 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    check("done_seen", sbq.size(), 0);
    sbq.delete();
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_run", bus.busy, 0);
  endtask
  initial begin
    int s;
    bus.start = 0;
    bus.abort = 0;
    bus.window = '0;
    bus.ro_div = 0;
    #1 reset = 1;
    #1;
    check("rst_ro_en", bus.ro_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.count, 0);
    check("rst_ovf", bus.ovf, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    measure(100, 10, 0);
    measure(0, 10, 0);
    measure(1, 5, 0);
    measure(200, 8, 0);
    launch(100, 10, s);
    repeat (49) @(posedge clk);
    #1 bus.abort = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    check("abort_ro_en", bus.ro_en, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_count_held", bus.count, CMAX);
    check("abort_ovf_held", bus.ovf, 1);
    repeat (80) @(posedge clk);
    #1 check("abort_stays_idle", bus.busy, 0);
    measure(16, 8, 0);
    measure(0, 6, 1);
    measure(100, 9, 1);
    launch(100, 10, s);
    repeat (39) @(posedge clk);
    #3 reset = 1;
    #1;
    check("arst_ro_en", bus.ro_en, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_count", bus.count, 0);
    check("arst_ovf", bus.ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    measure(40, 7, 0);
    for (int i = 0; i < 8; i++) measure($urandom_range(1, 300), $urandom_range(5, 12), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
